// File: rtl/idu_ctrl_flow_if.sv
// Decode-stage control-flow bus: fetch PC/instruction in, redirect/stall back to
// fetch, operands and EX hazard info in, ID/EX pipeline register out.
interface idu_ctrl_flow_if #(
    parameter int DataWidth = 32
);
    logic [DataWidth-1:0] ifu_pc;
    logic [DataWidth-1:0] ifu_fetch_inst;
    logic [DataWidth-1:0] rs1_data;
    logic [DataWidth-1:0] rs2_data;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ieu_stall;
    logic [4:0]           idu_rs1_addr;
    logic [4:0]           idu_rs2_addr;
    logic [1:0]           ifu_next_pc_sel;
    logic                 idu_branch;
    logic                 idu_flush;
    logic [1:0]           idu_stall;
    logic [DataWidth-1:0] idu_branch_addr;
    logic [DataWidth-1:0] idu_jal_addr;
    logic [DataWidth-1:0] idu_jalr_addr;
    logic [DataWidth-1:0] id_ex_pc;
    logic [DataWidth-1:0] id_ex_inst;
    logic                 id_ex_valid;

    modport slave (
        input  ifu_pc, ifu_fetch_inst, rs1_data, rs2_data, ex_mem_read, ex_rd, ieu_stall,
        output idu_rs1_addr, idu_rs2_addr, ifu_next_pc_sel, idu_branch, idu_flush, idu_stall,
        output idu_branch_addr, idu_jal_addr, idu_jalr_addr, id_ex_pc, id_ex_inst, id_ex_valid
    );

    modport master (
        output ifu_pc, ifu_fetch_inst, rs1_data, rs2_data, ex_mem_read, ex_rd, ieu_stall,
        input  idu_rs1_addr, idu_rs2_addr, ifu_next_pc_sel, idu_branch, idu_flush, idu_stall,
        input  idu_branch_addr, idu_jal_addr, idu_jalr_addr, id_ex_pc, id_ex_inst, id_ex_valid
    );
endinterface

// File: rtl/idu_ctrl_flow.sv
// Decode-stage control flow: JAL/JALR/BRANCH redirect, load-use and FENCE stalls,
// and the ID/EX pipeline register.
module idu_ctrl_flow #(
    parameter int DataWidth   = 32,
    parameter int FenceCycles = 4
) (
    input logic            brq_clk,
    input logic            brq_rst,
    idu_ctrl_flow_if.slave bus
);
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam int              CntW    = (FenceCycles > 1) ? $clog2(FenceCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(FenceCycles - 1);
    localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};

    logic [DataWidth-1:0] inst_s;
    logic [6:0]           op_s;
    logic [2:0]           funct3_s;
    logic [4:0]           rs1_s;
    logic [4:0]           rs2_s;
    logic [DataWidth-1:0] imm_j_s;
    logic [DataWidth-1:0] imm_b_s;
    logic [DataWidth-1:0] imm_i_s;
    logic                 uses_rs1_s;
    logic                 uses_rs2_s;
    logic                 load_use_s;
    logic                 fence_stall_s;
    logic                 stall_any_s;
    logic                 taken_s;
    logic [1:0]           sel_s;
    logic                 branch_s;
    logic                 flush_s;
    logic [0:0]           state_r;
    logic [CntW-1:0]      cnt_r;
    logic [DataWidth-1:0] id_ex_pc_r;
    logic [DataWidth-1:0] id_ex_inst_r;
    logic                 id_ex_valid_r;

    assign inst_s   = bus.ifu_fetch_inst;
    assign op_s     = inst_s[6:0];
    assign funct3_s = inst_s[14:12];
    assign rs1_s    = inst_s[19:15];
    assign rs2_s    = inst_s[24:20];

    assign imm_j_s = {{(DataWidth-20){inst_s[31]}}, inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};
    assign imm_b_s = {{(DataWidth-12){inst_s[31]}}, inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
    assign imm_i_s = {{(DataWidth-12){inst_s[31]}}, inst_s[31:20]};

    assign bus.idu_rs1_addr    = rs1_s;
    assign bus.idu_rs2_addr    = rs2_s;
    assign bus.idu_branch_addr = bus.ifu_pc + imm_b_s;
    assign bus.idu_jal_addr    = bus.ifu_pc + imm_j_s;
    assign bus.idu_jalr_addr   = (bus.rs1_data + imm_i_s) & ~{{(DataWidth-1){1'b0}}, 1'b1};

    assign uses_rs1_s = (op_s == OpJalr) || (op_s == OpBranch) || (op_s == OpLoad) ||
                        (op_s == OpStore) || (op_s == OpOpImm) || (op_s == OpOp);
    assign uses_rs2_s = (op_s == OpBranch) || (op_s == OpStore) || (op_s == OpOp);
    assign load_use_s = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((uses_rs1_s && (bus.ex_rd == rs1_s)) || (uses_rs2_s && (bus.ex_rd == rs2_s)));

    // Branch condition from funct3; reserved encodings never take
    always_comb begin
        taken_s = 1'b0;
        case (funct3_s)
            3'b000:  taken_s = (bus.rs1_data == bus.rs2_data);
            3'b001:  taken_s = (bus.rs1_data != bus.rs2_data);
            3'b100:  taken_s = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
            3'b101:  taken_s = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
            3'b110:  taken_s = (bus.rs1_data <  bus.rs2_data);
            3'b111:  taken_s = (bus.rs1_data >= bus.rs2_data);
            default: taken_s = 1'b0;
        endcase
    end

    // FENCE drain stall depends only on FSM state and decode, never on ieu_stall
    always_comb begin
        fence_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((op_s == OpFence) && !load_use_s) begin
                    fence_stall_s = 1'b1;
                end else begin
                    fence_stall_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (cnt_r != CntZero) begin
                    fence_stall_s = 1'b1;
                end else begin
                    fence_stall_s = 1'b0;
                end
            end
            default: fence_stall_s = 1'b0;
        endcase
    end

    assign stall_any_s   = load_use_s || fence_stall_s;
    assign bus.idu_stall = {fence_stall_s, load_use_s};

    // Next-PC select and flush; any stall defers the redirect
    always_comb begin
        sel_s    = 2'b00;
        branch_s = 1'b0;
        flush_s  = 1'b0;
        if (stall_any_s) begin
            sel_s    = 2'b00;
            branch_s = 1'b0;
            flush_s  = 1'b0;
        end else begin
            case (op_s)
                OpJal: begin
                    sel_s   = 2'b10;
                    flush_s = 1'b1;
                end
                OpJalr: begin
                    sel_s   = 2'b11;
                    flush_s = 1'b1;
                end
                OpBranch: begin
                    sel_s    = 2'b01;
                    branch_s = taken_s;
                    flush_s  = taken_s;
                end
                default: begin
                    sel_s    = 2'b00;
                    branch_s = 1'b0;
                    flush_s  = 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_next_pc_sel = sel_s;
    assign bus.idu_branch      = branch_s;
    assign bus.idu_flush       = flush_s;

    // FENCE drain sequencer; frozen while execute stalls
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CntZero;
        end else if (bus.ieu_stall) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fence_stall_s) begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= CntLoad;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r != CntZero) begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= cnt_r - CntW'(1);
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CntZero;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CntZero;
                end
            endcase
        end
    end

    // ID/EX pipeline register; a stall inserts a bubble but keeps the PC
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            id_ex_pc_r    <= {DataWidth{1'b0}};
            id_ex_inst_r  <= {DataWidth{1'b0}};
            id_ex_valid_r <= 1'b0;
        end else if (bus.ieu_stall) begin
            id_ex_pc_r    <= id_ex_pc_r;
            id_ex_inst_r  <= id_ex_inst_r;
            id_ex_valid_r <= id_ex_valid_r;
        end else if (stall_any_s) begin
            id_ex_pc_r    <= bus.ifu_pc;
            id_ex_inst_r  <= {DataWidth{1'b0}};
            id_ex_valid_r <= 1'b0;
        end else begin
            id_ex_pc_r    <= bus.ifu_pc;
            id_ex_inst_r  <= inst_s;
            id_ex_valid_r <= (inst_s != {DataWidth{1'b0}});
        end
    end

    assign bus.id_ex_pc    = id_ex_pc_r;
    assign bus.id_ex_inst  = id_ex_inst_r;
    assign bus.id_ex_valid = id_ex_valid_r;
endmodule

// File: tb/tb_idu_ctrl_flow.sv
// Bench for idu_ctrl_flow: directed literal cases plus a randomized fetch stream,
// both checked every cycle against a reference model built from the instruction rules.
module tb_idu_ctrl_flow;
    localparam int DW = 32;
    localparam int FC = 4;

    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_FEN = 7'b0001111, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011, OP_OP = 7'b0110011, OP_LUI = 7'b0110111;

    logic brq_clk = 1'b0;
    logic brq_rst;
    always #5 brq_clk = ~brq_clk;

    idu_ctrl_flow_if #(.DataWidth(DW)) bus ();
    idu_ctrl_flow #(.DataWidth(DW), .FenceCycles(FC)) dut (
        .brq_clk(brq_clk),
        .brq_rst(brq_rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // reference model state: ID/EX contents and FENCE stall cycles already spent
    int          m_done = 0;
    logic [31:0] m_pc, m_inst;
    logic        m_valid;

    // most recent expectations, also used to steer the random fetch stream
    logic [1:0]  e_sel, e_st;
    logic        e_br, e_fl;
    logic [31:0] e_ba, e_ja, e_jra;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] pc, inst, a, b, input logic mr,
                                  input logic [4:0] rd, input int done,
                                  output logic [1:0] sel, output logic br, output logic fl,
                                  output logic [1:0] st, output logic [31:0] ba,
                                  output logic [31:0] ja, output logic [31:0] jra);
        logic [6:0] op;
        logic u1, u2, lu, fs, tk;
        int bimm, jimm, iimm;
        op   = inst[6:0];
        u1   = op inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
        u2   = op inside {OP_BR, OP_ST, OP_OP};
        lu   = mr && (rd != 5'd0) && ((u1 && rd == inst[19:15]) || (u2 && rd == inst[24:20]));
        fs   = (done > 0) ? (done < FC) : (op == OP_FEN && !lu);
        st   = {fs, lu};
        bimm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        jimm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
        iimm = $signed(inst[31:20]);
        ba   = pc + bimm;
        ja   = pc + jimm;
        jra  = (a + iimm) & 32'hFFFF_FFFE;
        case (inst[14:12])
            3'b000:  tk = (a == b);
            3'b001:  tk = (a != b);
            3'b100:  tk = (int'(a) < int'(b));
            3'b101:  tk = !(int'(a) < int'(b));
            3'b110:  tk = (a < b);
            3'b111:  tk = !(a < b);
            default: tk = 1'b0;
        endcase
        sel = 2'd0; br = 1'b0; fl = 1'b0;
        if (st == 2'b00) begin
            if (op == OP_JAL)       begin sel = 2'd2; fl = 1'b1; end
            else if (op == OP_JALR) begin sel = 2'd3; fl = 1'b1; end
            else if (op == OP_BR)   begin sel = 2'd1; br = tk; fl = tk; end
        end
    endfunction

    // compare process: every output against the model, away from the active edge
    always @(negedge brq_clk) begin
        if (chk_en) begin
            model(bus.ifu_pc, bus.ifu_fetch_inst, bus.rs1_data, bus.rs2_data, bus.ex_mem_read,
                  bus.ex_rd, m_done, e_sel, e_br, e_fl, e_st, e_ba, e_ja, e_jra);
            cmp("m_sel", 32'(bus.ifu_next_pc_sel), 32'(e_sel));
            cmp("m_branch", 32'(bus.idu_branch), 32'(e_br));
            cmp("m_flush", 32'(bus.idu_flush), 32'(e_fl));
            cmp("m_stall", 32'(bus.idu_stall), 32'(e_st));
            cmp("m_baddr", bus.idu_branch_addr, e_ba);
            cmp("m_jaddr", bus.idu_jal_addr, e_ja);
            cmp("m_jraddr", bus.idu_jalr_addr, e_jra);
            cmp("m_rs", {22'd0, bus.idu_rs2_addr, bus.idu_rs1_addr},
                {22'd0, bus.ifu_fetch_inst[24:20], bus.ifu_fetch_inst[19:15]});
            cmp("m_idex_pc", bus.id_ex_pc, m_pc);
            cmp("m_idex_inst", bus.id_ex_inst, m_inst);
            cmp("m_idex_valid", 32'(bus.id_ex_valid), 32'(m_valid));
        end
    end

    // model state advance at the active edge
    always @(posedge brq_clk) begin : model_upd
        logic [1:0]  u_sel, u_st;
        logic        u_br, u_fl;
        logic [31:0] u_ba, u_ja, u_jra;
        model(bus.ifu_pc, bus.ifu_fetch_inst, bus.rs1_data, bus.rs2_data, bus.ex_mem_read,
              bus.ex_rd, m_done, u_sel, u_br, u_fl, u_st, u_ba, u_ja, u_jra);
        if (brq_rst) begin
            m_done <= 0; m_pc <= 32'd0; m_inst <= 32'd0; m_valid <= 1'b0;
        end else if (!bus.ieu_stall) begin
            m_done <= u_st[1] ? m_done + 1 : 0;
            m_pc   <= bus.ifu_pc;
            if (u_st != 2'b00) begin
                m_inst <= 32'd0; m_valid <= 1'b0;
            end else begin
                m_inst <= bus.ifu_fetch_inst; m_valid <= (bus.ifu_fetch_inst != 32'd0);
            end
        end
    end

    function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        logic [11:0] i;
        i = imm[11:0];
        return {i, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{OP_JAL, OP_JALR, OP_BR, OP_FEN, OP_LD, OP_ST, OP_IMM, OP_OP, OP_LUI, 7'd0};
        r = $urandom;
        return (r[3:0] > 4'd9) ? 32'd0 : {r[31:7], ops[r[3:0]]};
    endfunction

    task automatic drive(input logic [31:0] pc, inst, a, b, input logic mr, input logic [4:0] rd);
        bus.ifu_pc = pc; bus.ifu_fetch_inst = inst; bus.rs1_data = a; bus.rs2_data = b;
        bus.ex_mem_read = mr; bus.ex_rd = rd; bus.ieu_stall = 1'b0;
    endtask

    task automatic nxt();
        @(posedge brq_clk); #1;
    endtask

    // count FENCE stall cycles, optionally freezing execute for a window
    task automatic fence_run(input int st_at, input int st_len, output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            drive(32'h500, 32'h0FF0_000F, 32'd0, 32'd0, 1'b0, 5'd0);
            bus.ieu_stall = (k >= st_at) && (k < st_at + st_len);
            @(negedge brq_clk);
            if (bus.idu_stall[1]) n++;
            else break;
            nxt();
        end
        nxt();
        drive(32'h504, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("fence_issue_inst", bus.id_ex_inst, 32'h0FF0_000F);
        cmp("fence_issue_valid", 32'(bus.id_ex_valid), 32'd1);
        nxt();
    endtask

    initial begin : main
        logic [31:0] beq, blt, bltu, jalr, add, pc, inst;
        int n;
        brq_rst = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        nxt(); nxt();
        chk_en = 1'b1;
        @(negedge brq_clk);
        cmp("rst_valid", 32'(bus.id_ex_valid), 32'd0);
        cmp("rst_inst", bus.id_ex_inst, 32'd0);
        cmp("rst_stall_sel", {28'd0, bus.idu_stall, bus.ifu_next_pc_sel}, 32'd0);
        nxt();
        brq_rst = 1'b0;

        // JAL redirect then bubble
        drive(32'h100, 32'h0080_006F, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("jal_sel", 32'(bus.ifu_next_pc_sel), 32'd2);
        cmp("jal_flush", 32'(bus.idu_flush), 32'd1);
        cmp("jal_addr", bus.idu_jal_addr, 32'h108);
        nxt(); drive(32'h108, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("jal_flush_once", 32'(bus.idu_flush), 32'd0);
        cmp("jal_idex_valid", 32'(bus.id_ex_valid), 32'd1);
        nxt();
        @(negedge brq_clk);
        cmp("jal_bubble_valid", 32'(bus.id_ex_valid), 32'd0);
        nxt();

        // branches
        beq = enc_b(-8, 5'd2, 5'd1, 3'b000);
        drive(32'h200, beq, 32'd5, 32'd5, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("beq_taken", 32'(bus.idu_branch), 32'd1);
        cmp("beq_flush", 32'(bus.idu_flush), 32'd1);
        cmp("beq_addr", bus.idu_branch_addr, 32'h1F8);
        nxt(); drive(32'h200, beq, 32'd5, 32'd6, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("beq_nt", {29'd0, bus.idu_branch, bus.ifu_next_pc_sel}, 32'd1);
        cmp("beq_nt_flush", 32'(bus.idu_flush), 32'd0);
        blt = enc_b(-8, 5'd2, 5'd1, 3'b100);
        nxt(); drive(32'h200, blt, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("blt_taken", 32'(bus.idu_branch), 32'd1);
        bltu = enc_b(-8, 5'd2, 5'd1, 3'b110);
        nxt(); drive(32'h200, bltu, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("bltu_nt", 32'(bus.idu_branch), 32'd0);

        // JALR
        jalr = enc_i(2, 5'd1, 3'b000, 5'd5, OP_JALR);
        nxt(); drive(32'h300, jalr, 32'h1001, 32'd0, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("jalr_addr", bus.idu_jalr_addr, 32'h1002);
        cmp("jalr_sel_flush", {29'd0, bus.ifu_next_pc_sel, bus.idu_flush}, 32'b111);

        // load-use on ADD x4,x3,x1
        add = {7'd0, 5'd1, 5'd3, 3'b000, 5'd4, OP_OP};
        nxt(); drive(32'h400, add, 32'd0, 32'd0, 1'b1, 5'd3);
        @(negedge brq_clk);
        cmp("lu_stall", 32'(bus.idu_stall), 32'd1);
        nxt(); drive(32'h400, add, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge brq_clk);
        cmp("lu_clear", 32'(bus.idu_stall), 32'd0);
        cmp("lu_bubble", {bus.id_ex_pc[30:0], bus.id_ex_valid}, {31'h400, 1'b0});
        nxt(); drive(32'h404, add, 32'd0, 32'd0, 1'b1, 5'd0);
        @(negedge brq_clk);
        cmp("lu_issue", bus.id_ex_inst, add);
        cmp("lu_rd0_nostall", 32'(bus.idu_stall), 32'd0);
        nxt();

        // FENCE drain, with and without an execute freeze
        fence_run(99, 0, n);
        cmp("fence_cycles", n, 32'd4);
        fence_run(1, 2, n);
        cmp("fence_cycles_ieu", n, 32'd6);

        // reset in the middle of a drain
        drive(32'h500, 32'h0FF0_000F, 32'd0, 32'd0, 1'b0, 5'd0);
        nxt(); nxt();
        brq_rst = 1'b1; bus.ifu_fetch_inst = 32'd0;
        nxt();
        brq_rst = 1'b0;
        @(negedge brq_clk);
        cmp("rst_drain_stall", 32'(bus.idu_stall), 32'd0);
        cmp("rst_drain_idex", {bus.id_ex_inst[30:0], bus.id_ex_valid}, 32'd0);

        // taken branch deferred by a load-use hazard
        nxt(); drive(32'h600, beq, 32'd5, 32'd5, 1'b1, 5'd1);
        @(negedge brq_clk);
        cmp("brlu_stall", {27'd0, bus.idu_stall, bus.idu_flush, bus.ifu_next_pc_sel}, 32'b01000);
        nxt(); drive(32'h600, beq, 32'd5, 32'd5, 1'b0, 5'd1);
        @(negedge brq_clk);
        cmp("brlu_redirect", {29'd0, bus.idu_flush, bus.ifu_next_pc_sel}, 32'b101);

        // randomized fetch stream steered by the model's own redirect/stall decisions
        pc = 32'h1000; inst = rand_inst();
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if (e_st == 2'b00 && !bus.ieu_stall) begin
                if (e_fl) begin
                    pc = (e_sel == 2'd2) ? e_ja : (e_sel == 2'd3) ? e_jra : e_ba;
                    inst = 32'd0;
                end else begin
                    pc = pc + 32'd4;
                    inst = rand_inst();
                end
            end
            drive(pc, inst, $urandom, $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0) ? inst[19:15] : 5'($urandom));
            if ($urandom_range(0, 2) == 0) bus.rs2_data = bus.rs1_data;
            bus.ieu_stall = ($urandom_range(0, 9) == 0);
            brq_rst = ($urandom_range(0, 199) == 0);
        end
        nxt();
        brq_rst = 1'b0;
        @(negedge brq_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idu_ctrl_flow.md
Name: idu_ctrl_flow

Overview:
- Control-flow and hazard slice of the decode stage, directly downstream of the fetch unit.
- Consumes the fetched PC/instruction pair and decodes JAL, JALR, BRANCH and FENCE.
- Computes redirect targets, resolves branches, and drives next-PC select, flush and the 2-bit decode stall back to fetch.
- Registers the decoded instruction into the ID/EX pipeline register, inserting bubbles on stall.

Parameters:
DataWidth, 32, datapath/address width
FenceCycles, 4, stall cycles a FENCE holds decode (>=1)

Ports:
brq_clk  input  1  clock
brq_rst  input  1  synchronous active-high reset
ifu_pc  input  DataWidth  PC of instruction in decode
ifu_fetch_inst  input  DataWidth  instruction in decode; 0 = bubble
rs1_data  input  DataWidth  rs1 value (register file, already forwarded)
rs2_data  input  DataWidth  rs2 value (register file, already forwarded)
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  5  destination register of instruction in EX
ieu_stall  input  1  execute stage stall; freezes this block
idu_rs1_addr  output  5  inst[19:15]
idu_rs2_addr  output  5  inst[24:20]
ifu_next_pc_sel  output  2  00 PC+4, 01 branch, 10 JAL, 11 JALR
idu_branch  output  1  branch taken
idu_flush  output  1  squash instruction being fetched
idu_stall  output  2  [0] load-use, [1] FENCE drain
idu_branch_addr  output  DataWidth  ifu_pc + B-imm
idu_jal_addr  output  DataWidth  ifu_pc + J-imm
idu_jalr_addr  output  DataWidth  (rs1_data + I-imm) & ~1
id_ex_pc  output  DataWidth  registered PC to execute
id_ex_inst  output  DataWidth  registered instruction to execute
id_ex_valid  output  1  registered valid to execute

Behaviour:
- Reset: id_ex_pc/inst/valid = 0, FSM = IDLE, counter = 0. Combinational outputs follow a zero instruction: sel 00, branch 0, flush 0, stall 00.
- Immediates are sign-extended from inst bits: J 21b, B 13b, I 12b. All adds are mod 2^32. Target outputs are always driven, regardless of opcode.
- Decode opcodes:
  - 1101111 JAL: sel 10, flush 1.
  - 1100111 JALR: sel 11, flush 1.
  - 1100011 BRANCH: sel 01, flush = idu_branch.
  - 0001111 FENCE.
  - Anything else: sel 00.
- Branch funct3 compare of rs1_data vs rs2_data: 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu. Reserved funct3 gives idu_branch 0.
- Load-use: stall[0] = ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
- FENCE FSM (IDLE, DRAIN):
  - IDLE with FENCE decoded and no stall[0]: stall[1] = 1, cnt <= FenceCycles-1, go DRAIN.
  - DRAIN with cnt != 0: stall[1] = 1, cnt decrements.
  - DRAIN with cnt == 0: stall[1] = 0, FENCE issues to ID/EX, go IDLE.
  - Net effect: exactly FenceCycles stall cycles.
- Any stall bit set forces sel 00, branch 0, flush 0. Redirect is deferred until the stall clears.
- ieu_stall = 1: ID/EX, FSM and counter hold. Combinational outputs are still driven; fetch ignores them while stalled.
- ID/EX update when ieu_stall = 0:
  - Stall bit set: valid 0, inst 0, pc = ifu_pc.
  - Otherwise: pc/inst load from inputs, valid = (ifu_fetch_inst != 0).
- Redirect timing: sel/flush are valid in the cycle the control instruction sits in decode. Fetch loads the target at the next edge and its registered output becomes a bubble, so taken control transfers cost 1 bubble.
- Reset mid-DRAIN returns to IDLE with stall cleared next cycle. No combinational path from ieu_stall to idu_stall.

Test Plan:
- JAL 0x0080006F at ifu_pc 0x100 -> sel 10, jal_addr 0x108, flush 1 for one cycle. Next cycle decode sees inst 0, and id_ex_valid=0 a cycle later.
- BEQ with rs1=rs2=5, B-imm -8, pc 0x200 -> branch 1, flush 1, addr 0x1F8. Repeat with rs2=6 -> branch 0, flush 0, sel 01. Also BLT -1 vs 1 -> taken; BLTU -> not taken.
- JALR rs1=0x1001, imm 2 -> jalr_addr 0x1002, sel 11, flush 1.
- Load-use: ex_mem_read=1, ex_rd=3, ADD x4,x3,x1 in decode -> stall 01 for one cycle, ID/EX bubble, ADD issued next cycle. With ex_rd=0 -> no stall.
- FENCE, FenceCycles=4 -> stall[1] high exactly 4 cycles, FENCE enters ID/EX on the 5th. Raise ieu_stall 2 cycles mid-drain -> 6 stall cycles total. Assert brq_rst mid-drain -> stall 00 next cycle, ID/EX = 0.
- BEQ taken while load-use hazard on rs1 -> first cycle stall 01, flush 0, sel 00. Next cycle flush 1, sel 01.
